// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Brief    : Shared constants for the external-bus interface unit: state
//             encoding, board default widths and the wait-counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package bus_pkg;

    // Bus master state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;

    // Board default bus widths
    localparam int c_DEF_AW = 16;
    localparam int c_DEF_DW = 8;

    // Wait counter width: enough bits to hold maxval, never less than one
    function automatic int cnt_width(input int maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_waitcnt.sv
`default_nettype none
// ============================================================================
//  Module   : bus_waitcnt
//  Brief    : Wait-state counter with synchronous clear, count enable and a
//             terminal-count compare that can be disabled.
//  Revision : 1.0  initial release
// ============================================================================
module bus_waitcnt #(
    parameter int MAXVAL = 15,
    parameter int W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    input  logic i_tc_en,
    output logic o_tc
);

    localparam logic [W-1:0] c_TERM = W'(MAXVAL);

    logic [W-1:0] r_cnt;

    // Counter: clear has priority over increment; wraps only when compare is off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = i_tc_en && (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/bus_iface.sv
`default_nettype none
// ============================================================================
//  Module   : bus_iface
//  Brief    : Registered external-bus master for the 6502 core. Three-state
//             IDLE/ADDR/DATA sequencer with RDY wait states and an optional
//             wait-state timeout reported through err alongside ack.
//  Revision : 1.0  initial release
// ============================================================================
module bus_iface
    import bus_pkg::*;
#(
    parameter int AW      = c_DEF_AW,
    parameter int DW      = c_DEF_DW,
    parameter int MAXWAIT = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          err,
    output logic          busy,
    output logic [AW-1:0] ab,
    output logic [DW-1:0] dout,
    output logic          doe,
    output logic          rw,
    input  logic [DW-1:0] din,
    input  logic          rdy
);

    localparam int c_CW = cnt_width(MAXWAIT);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          w_start;
    logic          w_done;
    logic          w_tmo;
    logic          w_cnt_en;
    logic          w_tc;

    logic [AW-1:0] r_ab;
    logic [DW-1:0] r_dout;
    logic [DW-1:0] r_rdata;
    logic          r_rw;
    logic          r_doe;
    logic          r_ack;
    logic          r_err;
    logic          r_busy;

    // Wait-state counter; the terminal compare is disabled when MAXWAIT is 0
    bus_waitcnt #(
        .MAXVAL (MAXWAIT),
        .W      (c_CW)
    ) u_waitcnt (
        .clk     (clk),
        .rst     (clr),
        .i_clear (w_start),
        .i_en    (w_cnt_en),
        .i_tc_en (MAXWAIT != 0),
        .o_tc    (w_tc)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; rdy=1 is checked before the timeout so it wins a tie
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    w_start     = 1'b1;
                    w_state_nxt = c_ADDR;
                end
            end
            c_ADDR: begin
                w_state_nxt = c_DATA;
            end
            c_DATA: begin
                if (rdy) begin
                    w_done      = 1'b1;
                    w_state_nxt = c_IDLE;
                end else if (w_tc) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_en    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output registers: pins latched at start, released at completion or timeout
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_ab    <= '0;
            r_dout  <= '0;
            r_rdata <= '0;
            r_rw    <= 1'b1;
            r_doe   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack  <= w_done | w_tmo;
            r_err  <= w_tmo;
            r_busy <= (w_state_nxt != c_IDLE);
            if (w_start) begin
                r_ab   <= addr;
                r_dout <= wdata;
                r_rw   <= ~we;
                r_doe  <= we;
            end
            if (w_done && r_rw) begin
                r_rdata <= din;
            end
            if (w_done || w_tmo) begin
                r_rw  <= 1'b1;
                r_doe <= 1'b0;
            end
        end
    end

    assign ab    = r_ab;
    assign dout  = r_dout;
    assign rdata = r_rdata;
    assign rw    = r_rw;
    assign doe   = r_doe;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bus_iface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_iface
//  Brief    : Directed self-checking bench for bus_iface with an expected-
//             result queue; a second instance covers the no-timeout setting.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_iface;
    import bus_pkg::*;

    localparam int AW = c_DEF_AW;
    localparam int DW = c_DEF_DW;
    localparam int MW = 3;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          req = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] din   = '0;
    logic          rdy   = 1'b0;
    logic [DW-1:0] rdata;
    logic          ack, err, busy, doe, rw;
    logic [AW-1:0] ab;
    logic [DW-1:0] dout;

    logic          req0 = 1'b0;
    logic          rdy0 = 1'b0;
    logic [DW-1:0] din0 = 8'h9C;
    logic [AW-1:0] addr0 = 16'h0200;
    logic [DW-1:0] wdata0 = 8'h00;
    logic          we0 = 1'b0;
    logic [DW-1:0] rdata0;
    logic          ack0, err0, busy0, doe0, rw0;
    logic [AW-1:0] ab0;
    logic [DW-1:0] dout0;

    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] model_rdata = '0;
    exp_t          sb[$];

    always #5 clk = ~clk;

    bus_iface #(.AW(AW), .DW(DW), .MAXWAIT(MW)) dut (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .ab(ab), .dout(dout),
        .doe(doe), .rw(rw), .din(din), .rdy(rdy)
    );

    bus_iface #(.AW(AW), .DW(DW), .MAXWAIT(0)) dut0 (
        .clk(clk), .clr(clr), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0), .ab(ab0), .dout(dout0),
        .doe(doe0), .rw(rw0), .din(din0), .rdy(rdy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transfer; called at a negedge. rdy is low for the first nwait DATA edges.
    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] di, input int nwait);
        exp_t e;
        int   k;
        bit   got;
        bit   tmo;
        int   exp_idx;
        tmo     = (nwait > MW);
        exp_idx = tmo ? MW : nwait;
        if (!w && !tmo) model_rdata = di;
        e.rdata = model_rdata;
        e.err   = tmo;
        sb.push_back(e);

        req = 1'b1; we = w; addr = a; wdata = wd; din = di; rdy = 1'b1;
        step();
        req = 1'b0; we = !w; addr = ~a; wdata = ~wd;
        chk("start_ab", ab, a);
        chk("start_rw", rw, !w);
        chk("start_doe", doe, w);
        chk("start_busy", busy, 1);
        if (w) chk("start_dout", dout, wd);
        step();
        chk("addr_noack", ack, 0);
        chk("addr_ab_held", ab, a);
        rdy = (nwait == 0);
        k = 0;
        got = 0;
        while (!got && k < 50) begin
            step();
            if (ack) begin
                got = 1;
            end else begin
                k++;
                rdy = (k >= nwait);
                if (w) chk("wait_doe", doe, 1);
            end
        end
        chk("ack_seen", got, 1);
        chk("ack_latency", k, exp_idx);
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", err, e.err);
        chk("end_rw", rw, 1);
        chk("end_doe", doe, 0);
        chk("end_busy", busy, 0);
        rdy = 1'b0;
        step();
        chk("ack_pulse", ack, 0);
        chk("err_pulse", err, 0);
        chk("idle_ab_kept", ab, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   nack;

        // Reset with a request pending must leave everything at reset values
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ab", ab, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rw", rw, 1);
        chk("rst_doe", doe, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ab0", ab0, 0);
        req = 1'b0;
        clr = 1'b0;
        step();

        xfer(1'b0, 16'h1234, 8'h00, 8'hA5, 0);     // read, no waits
        xfer(1'b1, 16'h00FF, 8'h3C, 8'hEE, 2);     // write, two waits
        xfer(1'b0, 16'h4321, 8'h00, 8'h5E, MW);    // rdy wins at terminal count
        xfer(1'b0, 16'h0002, 8'h00, 8'h77, 100);   // timeout

        // Back-to-back reads with req held high
        req = 1'b1; we = 1'b0; addr = 16'h0010; din = 8'h11; rdy = 1'b1;
        model_rdata = 8'h11;
        e.rdata = 8'h11; e.err = 1'b0;
        sb.push_back(e);
        step();
        chk("b2b_ab1", ab, 16'h0010);
        addr = 16'h0011;
        step();
        chk("b2b_ab1_held", ab, 16'h0010);
        step();
        chk("b2b_ack1", ack, 1);
        e = sb.pop_front();
        chk("b2b_rdata1", rdata, e.rdata);
        din = 8'h22;
        model_rdata = 8'h22;
        e.rdata = 8'h22; e.err = 1'b0;
        sb.push_back(e);
        step();
        chk("b2b_gap1", ack, 0);
        chk("b2b_ab2", ab, 16'h0011);
        chk("b2b_busy2", busy, 1);
        req = 1'b0;
        step();
        chk("b2b_gap2", ack, 0);
        step();
        chk("b2b_ack2", ack, 1);
        e = sb.pop_front();
        chk("b2b_rdata2", rdata, e.rdata);
        rdy = 1'b0;
        step();
        chk("b2b_ack2_pulse", ack, 0);

        // Abort a write during a DATA wait state
        req = 1'b1; we = 1'b1; addr = 16'h0ABC; wdata = 8'h5A; rdy = 1'b0;
        step();
        req = 1'b0;
        step();
        step();
        chk("abort_doe_pre", doe, 1);
        #2 clr = 1'b1;
        #1;
        chk("abort_doe", doe, 0);
        chk("abort_rw", rw, 1);
        chk("abort_ab", ab, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rdata", rdata, 0);
        @(negedge clk);
        clr = 1'b0;
        rdy = 1'b1;
        nack = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ack) nack++;
        end
        chk("abort_no_ack", nack, 0);
        rdy = 1'b0;

        // No timeout when MAXWAIT is 0
        req0 = 1'b1; rdy0 = 1'b0;
        step();
        req0 = 1'b0;
        nack = 0;
        for (int i = 0; i < 41; i++) begin
            step();
            if (ack0) nack++;
        end
        chk("mw0_no_ack", nack, 0);
        chk("mw0_busy", busy0, 1);
        rdy0 = 1'b1;
        step();
        chk("mw0_ack", ack0, 1);
        chk("mw0_err", err0, 0);
        chk("mw0_rdata", rdata0, 8'h9C);
        rdy0 = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_iface.md
# bus_iface

Parametrised external-bus interface unit for the 6502 core. It replaces the fixed 8-bit address-high/address-low/data-output registers at the board level with a single registered bus master. It is generic in address and data width and adds RDY-style wait-state handling and a wait-state timeout. It sits between the instruction-decode control signals (request side) and the external pins (address, data, rw).

## Interface
Parameters:
- AW, 16, address bus width (≥ 2)
- DW, 8, data bus width (≥ 1)
- MAXWAIT, 15, maximum wait states before timeout; 0 disables timeout

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  reset; asynchronous and active-high
- req  in  1  core transfer request, level, sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  AW  transfer address; sampled with req
- wdata  in  DW  write data; sampled with req
- rdata  out  DW  read data, held until next completed read
- ack  out  1  one-cycle completion pulse
- err  out  1  one-cycle timeout flag, coincident with ack
- busy  out  1  high whenever state ≠ IDLE
- ab  out  AW  external address bus
- dout  out  DW  external write data
- doe  out  1  external data output enable
- rw  out  1  external read/write, 1 = read
- din  in  DW  external read data
- rdy  in  1  external ready; 0 inserts a wait state

## Operation
- The state machine has three states: IDLE, ADDR, DATA. All outputs are registered.
- **IDLE**
  - If req=1 at an edge: latch ab←addr, dout←wdata, rw←~we, doe←we; clear wait counter; go to ADDR.
  - Otherwise hold. In IDLE, ab keeps its last value, rw=1 and doe=0.
- **ADDR**
  - Unconditionally go to DATA.
  - rdy is ignored in this state.
- **DATA**, evaluated at each edge:
  - rdy=1:
    - For a read, rdata←din.
    - ack←1; rw←1; doe←0; go to IDLE.
  - rdy=0, with MAXWAIT≠0 and wcnt==MAXWAIT:
    - ack←1 and err←1; rdata unchanged.
    - rw←1; doe←0; go to IDLE.
  - rdy=0 otherwise: wcnt←wcnt+1; stay in DATA.
- ack and err clear at the next edge unconditionally.
- wcnt width is max(1, clog2(MAXWAIT+1)). wcnt saturates and never wraps because the timeout fires first.
- With MAXWAIT=0, wcnt still counts but wraps harmlessly; no timeout occurs.
- A write never modifies rdata.
- Reset values: state=IDLE, ab=0, dout=0, rw=1, doe=0, rdata=0, ack=0, err=0, busy=0, wcnt=0.
- Reset asserted mid-transfer aborts immediately to reset values. No ack is issued for the aborted transfer.

## Timing
- req=1 sampled at edge E0 → ab/rw/doe valid after E0 → ADDR.
- E1 → DATA.
- rdy=1 at E2 → ack high from E2 to E3; rdata valid from E2.
- Minimum latency is 3 cycles request-to-ack. Each wait state adds 1 cycle.
- A timeout acks after MAXWAIT+3 cycles.
- Back-to-back transfers:
  - The state returns to IDLE at the same edge that raises ack.
  - If req is still high at the next edge (E3), a new transfer starts at E3.
  - The core must drop req during the ack cycle unless it wants another transfer.
  - Sustained throughput is 1 transfer per 3 cycles.
- req, we, addr and wdata changes while busy=1 are ignored.
- rdy toggling during ADDR has no effect. Only the rdy value at DATA edges matters.
- The rdy=1 check has priority over timeout: rdy=1 arriving exactly at wcnt==MAXWAIT completes normally with err=0.

## Structure
- Shared package bus_pkg holds:
  - the state encoding constants IDLE=2'd0, ADDR=2'd1, DATA=2'd2;
  - the default-width constants (16/8) used by the board.
- One sub-module, bus_waitcnt: a parametrised counter with clear, enable, terminal-compare and a disable-when-zero input.
- The top FSM, output registers and read-data latch live in bus_iface.

## Test plan
- **Reset:** assert clr mid-run → all outputs at reset values; ab=0000, rw=1, doe=0, ack=0.
- **Read, no waits:** req, we=0, addr=0x1234, din=0xA5, rdy=1 → ab=0x1234 one cycle after req sampled; ack 3 cycles after; rdata=0xA5, err=0.
- **Write with 2 waits:** addr=0x00FF, wdata=0x3C, rdy low for 2 DATA edges → rw=0 and doe=1 with dout=0x3C through ADDR and DATA; ack at cycle 5; rw returns to 1; rdata unchanged.
- **Timeout:** MAXWAIT=3, rdy held 0 → ack and err high together at cycle 6. With MAXWAIT=0 and rdy=0 for 40 cycles → no ack.
- **Back-to-back:** req held high over two reads (0x0010→0x11, 0x0011→0x22) → ack pulses 3 cycles apart; second ab update on the edge after the first ack.
- **Abort:** clr during the DATA wait state of a write → doe=0 and rw=1 immediately (asynchronous); no ack ever issued for that write.
